add16_sched: RTL and testbench

Round-robin scheduler that shares one `add4bit` ripple adder between two requesters to perform WIDTH-bit additions nibble-serially. Each accepted request takes WIDTH/4 passes through the shared adder, carrying between nibbles in a register. The result and carry-out are then returned with a one-cycle done pulse to the owning requester. It sits between operand-producing blocks and the single `add4bit` datapath instance; it is the only place `add4bit` is instantiated.

---
 rtl/add16_sched.sv | 155 +++++++++++++++
 tb/tb_add16_sched.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/add16_sched.sv
// add16_sched: round-robin scheduler that shares a single 4-bit ripple adder
// between two requesters to perform WIDTH-bit additions one nibble at a time.
// add4bit is the shared nibble datapath and is instantiated only here.

module add4bit (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_cout
);

  logic [4:0] w_c;

  // Four chained full adders; the carry ripples from bit 0 upward.
  always_comb begin
    w_c    = '0;
    o_sum  = '0;
    w_c[0] = i_cin;
    for (int i = 0; i < 4; i++) begin
      o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
      w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
    end
    o_cout = w_c[4];
  end

endmodule

module add16_sched #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             cin0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic             cin1,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             done0,
  output logic             done1,
  output logic             busy,
  output logic             owner
);

  localparam int N    = WIDTH / 4;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_t;

  state_t            r_state;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [WIDTH-1:0]  r_work;
  logic              r_carry;
  logic [IDXW-1:0]   r_idx;
  logic              r_prio;

  logic              w_anyReq;
  logic              w_grant;
  logic [IDXW+1:0]   w_base;
  logic              w_lastNib;
  logic [3:0]        w_aNib;
  logic [3:0]        w_bNib;
  logic [3:0]        w_nibSum;
  logic              w_nibCout;
  logic [WIDTH-1:0]  w_workNext;

  // A lone request wins outright; when both ask, the priority pointer decides.
  assign w_anyReq  = req0 | req1;
  assign w_grant   = (req0 && req1) ? r_prio : req1;
  assign w_base    = {r_idx, 2'b00};
  assign w_lastNib = (r_idx == IDXW'(N - 1));
  assign w_aNib    = r_a[w_base +: 4];
  assign w_bNib    = r_b[w_base +: 4];

  add4bit u_add4bit (
    .i_a    (w_aNib),
    .i_b    (w_bNib),
    .i_cin  (r_carry),
    .o_sum  (w_nibSum),
    .o_cout (w_nibCout)
  );

  // Work register with the current nibble replaced, so the final pass can be
  // published to sum on the same edge it is computed.
  always_comb begin
    w_workNext               = r_work;
    w_workNext[w_base +: 4]  = w_nibSum;
  end

  // Scheduler FSM: grant in IDLE, one nibble per cycle in ADD, pulse in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_work  <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_prio  <= 1'b0;
      sum     <= '0;
      c_out   <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      busy    <= 1'b0;
      owner   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_anyReq) begin
            r_a     <= w_grant ? a1 : a0;
            r_b     <= w_grant ? b1 : b0;
            r_carry <= w_grant ? cin1 : cin0;
            owner   <= w_grant;
            r_prio  <= ~w_grant;
            r_idx   <= '0;
            busy    <= 1'b1;
            r_state <= ADD;
          end
        end
        ADD: begin
          r_work  <= w_workNext;
          r_carry <= w_nibCout;
          r_idx   <= r_idx + 1'b1;
          if (w_lastNib) begin
            sum     <= w_workNext;
            c_out   <= w_nibCout;
            done0   <= ~owner;
            done1   <= owner;
            r_state <= DONE;
          end
        end
        DONE: begin
          done0   <= 1'b0;
          done1   <= 1'b0;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_add16_sched.sv
// tb_add16_sched: directed bench for add16_sched with a cycle-level
// behavioural model compared against the DUT on every cycle.

module tb_add16_sched;

  localparam int WIDTH = 16;
  localparam int N     = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0, req1, cin0, cin1;
  logic [WIDTH-1:0] a0, b0, a1, b1;
  logic [WIDTH-1:0] sum;
  logic             c_out, done0, done1, busy, owner;

  int nChecks = 0;
  int nFails  = 0;
  bit checkEn = 1'b0;
  int cycleNo = 0;

  int mCnt  = 0;
  bit mPrio = 1'b0;
  bit mOwner = 1'b0;
  logic [WIDTH-1:0] mSum = '0;
  bit mCout  = 1'b0;
  bit mDone0 = 1'b0;
  bit mDone1 = 1'b0;
  logic [WIDTH:0] mPend = '0;
  bit mGrant;

  int doneLog[$];
  int doneCyc[$];

  always #5 clk = ~clk;

  add16_sched #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .req0  (req0),
    .a0    (a0),
    .b0    (b0),
    .cin0  (cin0),
    .req1  (req1),
    .a1    (a1),
    .b1    (b1),
    .cin1  (cin1),
    .sum   (sum),
    .c_out (c_out),
    .done0 (done0),
    .done1 (done1),
    .busy  (busy),
    .owner (owner)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycleNo);
    end
  endtask

  task automatic timeoutFail(input string name);
    nChecks++;
    nFails++;
    $display("[TB] FAIL %s: timed out waiting (cycle %0d)", name, cycleNo);
  endtask

  // Model: an accepted request keeps the unit busy for N+1 cycles, the last
  // of which delivers a+b+cin and a done pulse to its owner.
  always @(posedge clk) begin
    cycleNo++;
    if (rst) begin
      mCnt = 0; mPrio = 0; mOwner = 0; mSum = '0; mCout = 0; mDone0 = 0; mDone1 = 0;
    end else begin
      mDone0 = 0;
      mDone1 = 0;
      if (mCnt == 0) begin
        if (req0 || req1) begin
          mGrant = (req0 && req1) ? mPrio : req1;
          mOwner = mGrant;
          mPrio  = !mGrant;
          mPend  = mGrant ? ({1'b0, a1} + {1'b0, b1} + cin1) : ({1'b0, a0} + {1'b0, b0} + cin0);
          mCnt   = N + 1;
        end
      end else begin
        mCnt--;
        if (mCnt == 1) begin
          {mCout, mSum} = mPend;
          if (mOwner) mDone1 = 1;
          else        mDone0 = 1;
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model, away from the edge.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("busy", 32'(busy), 32'(mCnt != 0));
      checkOutput("owner", 32'(owner), 32'(mOwner));
      checkOutput("sum", 32'(sum), 32'(mSum));
      checkOutput("c_out", 32'(c_out), 32'(mCout));
      checkOutput("done0", 32'(done0), 32'(mDone0));
      checkOutput("done1", 32'(done1), 32'(mDone1));
      checkOutput("done_exclusive", 32'(done0 & done1), 32'd0);
      if (done0 === 1'b1) begin doneLog.push_back(0); doneCyc.push_back(cycleNo); end
      if (done1 === 1'b1) begin doneLog.push_back(1); doneCyc.push_back(cycleNo); end
    end
  end

  task automatic applyStimulus(input bit who, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin);
    if (who) begin a1 = a; b1 = b; cin1 = cin; req1 = 1'b1; end
    else     begin a0 = a; b0 = b; cin0 = cin; req0 = 1'b1; end
  endtask

  task automatic waitGrant(input bit who);
    bit got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (busy === 1'b1 && owner === who) got = 1;
    end
    if (!got) timeoutFail("grant");
  endtask

  task automatic waitDone(input bit who, output int cyc);
    bit got = 0;
    cyc = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      cyc++;
      if ((who ? done1 : done0) === 1'b1) got = 1;
    end
    if (!got) timeoutFail("done");
  endtask

  task automatic waitIdle();
    bit got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (busy === 1'b0) got = 1;
    end
    if (!got) timeoutFail("idle");
  endtask

  // One complete transaction from a single requester with literal result checks.
  task automatic runOne(input bit who, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin, input logic [WIDTH-1:0] expSum, input logic expC, input string tag);
    int cyc;
    applyStimulus(who, a, b, cin);
    waitGrant(who);
    req0 = 1'b0;
    req1 = 1'b0;
    waitDone(who, cyc);
    checkOutput({tag, "_latency"}, 32'(cyc), 32'(N));
    checkOutput({tag, "_sum"}, 32'(sum), 32'(expSum));
    checkOutput({tag, "_cout"}, 32'(c_out), 32'(expC));
    checkOutput({tag, "_owner"}, 32'(owner), 32'(who));
    waitIdle();
  endtask

  initial begin
    int cyc;
    rst = 1'b1;
    req0 = 1'b1; a0 = 16'h1234; b0 = 16'h0FFF; cin0 = 1'b0;
    req1 = 1'b1; a1 = 16'hAAAA; b1 = 16'h5555; cin1 = 1'b1;

    // Reset with both requests high; requester 0 must win right after release.
    @(posedge clk);
    checkEn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_sum", 32'(sum), 32'h0);
    checkOutput("rst_cout", 32'(c_out), 32'h0);
    checkOutput("rst_done", 32'({done0, done1}), 32'h0);
    checkOutput("rst_busy_owner", 32'({busy, owner}), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("first_grant_busy", 32'(busy), 32'h1);
    checkOutput("first_grant_owner", 32'(owner), 32'h0);
    req0 = 1'b0;
    req1 = 1'b0;
    waitDone(1'b0, cyc);
    checkOutput("t1_latency", 32'(cyc), 32'(N));
    checkOutput("t1_sum", 32'(sum), 32'h2233);
    checkOutput("t1_cout", 32'(c_out), 32'h0);
    waitIdle();

    // Carry ripple through all nibbles, then overflow from requester 1.
    runOne(1'b0, 16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, "ripple");
    runOne(1'b1, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, "ovf");

    // Both requests held high: grants alternate, one done every N+2 cycles.
    doneLog.delete();
    doneCyc.delete();
    applyStimulus(1'b0, 16'h0101, 16'h0202, 1'b0);
    applyStimulus(1'b1, 16'h8000, 16'h8000, 1'b1);
    for (int i = 0; i < 60 && doneLog.size() < 4; i++) begin
      @(negedge clk);
      #1;
    end
    req0 = 1'b0;
    req1 = 1'b0;
    if (doneLog.size() < 4) timeoutFail("arb_dones");
    else begin
      checkOutput("arb_order", 32'({doneLog[0][1:0], doneLog[1][1:0], doneLog[2][1:0], doneLog[3][1:0]}), 32'b00010001);
      for (int i = 1; i < 4; i++) checkOutput("arb_period", 32'(doneCyc[i] - doneCyc[i-1]), 32'(N + 2));
    end
    waitIdle();
    waitIdle();

    // Operand changes and req drop after grant must not disturb the result.
    applyStimulus(1'b0, 16'h0001, 16'h0002, 1'b0);
    waitGrant(1'b0);
    a0 = 16'hFFFF;
    req0 = 1'b0;
    waitDone(1'b0, cyc);
    checkOutput("iso_sum", 32'(sum), 32'h0003);
    repeat (3) @(negedge clk);
    checkOutput("iso_no_rerequest", 32'(busy), 32'h0);

    // Reset during ADD (idx=2) aborts the operation and clears the held result.
    runOne(1'b0, 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, "pre_rst");
    applyStimulus(1'b0, 16'h1111, 16'h1111, 1'b0);
    waitGrant(1'b0);
    req0 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_sum", 32'(sum), 32'h0);
    checkOutput("midrst_busy", 32'(busy), 32'h0);
    checkOutput("midrst_done0", 32'(done0), 32'h0);
    repeat (6) @(negedge clk);
    checkOutput("midrst_still_zero", 32'(sum), 32'h0);
    runOne(1'b0, 16'h0005, 16'h0007, 1'b0, 16'h000C, 1'b0, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
